// File: rtl/mainreg_bank.sv
// Main register file: NREGS x WIDTH registers, top register is the index register IX.
// Optional shadow bank with EXX exchange is enabled by defining MAINREG_BANK_SHADOW_EN.
module mainreg_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 4,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic                   CLK,
  input  logic                   RESET,
`ifdef MAINREG_BANK_SHADOW_EN
  input  logic                   EXX,
`endif
  input  logic [1:0]             OP,
  input  logic [AW-1:0]          WA,
  input  logic [WIDTH-1:0]       IN,
  input  logic [AW-1:0]          RA,
  input  logic [AW-1:0]          RB,
  input  logic                   CSEL,
  input  logic [WIDTH-1:0]       STEP,
  output logic [WIDTH-1:0]       OUTA,
  output logic [WIDTH-1:0]       OUTB,
  output logic [WIDTH-1:0]       OUTC,
  output logic [WIDTH-1:0]       OIX,
  output logic                   IXZ,
  output logic [NREGS*WIDTH-1:0] REGS
);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SWAP   = 2'b10;
  localparam logic [1:0] OP_IXSTEP = 2'b11;

  localparam logic [AW-1:0] IX_IDX = AW'(NREGS - 1);

`ifdef MAINREG_BANK_SHADOW_EN
  localparam int unsigned NBANKS = 2;
  logic bsel_q;

  // The OP acts on the pre-toggle bank because bsel_q only changes at the same edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bsel_q <= 1'b0;
    end else begin
      bsel_q <= bsel_q ^ EXX;
    end
  end
`else
  localparam int unsigned NBANKS = 1;
  logic bsel_q;
  assign bsel_q = 1'b0;
`endif

  logic [WIDTH-1:0] regs_q [NBANKS][NREGS];
  logic [WIDTH-1:0] regs_d [NBANKS][NREGS];
  logic             ixz_q;
  logic             ixz_d;
  logic [WIDTH-1:0] ix_sum;

  always_comb begin
    regs_d = regs_q;
    ixz_d  = ixz_q;
    ix_sum = regs_q[bsel_q][IX_IDX] + STEP;
    unique case (OP)
      OP_NOP: ;
      OP_WRITE: regs_d[bsel_q][WA] = IN;
      // RA==RB writes the same value back, so no special case is needed.
      OP_SWAP: begin
        regs_d[bsel_q][RA] = regs_q[bsel_q][RB];
        regs_d[bsel_q][RB] = regs_q[bsel_q][RA];
      end
      OP_IXSTEP: begin
        regs_d[bsel_q][IX_IDX] = ix_sum;
        ixz_d                  = (ix_sum == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int b = 0; b < NBANKS; b++) begin
        for (int i = 0; i < NREGS; i++) begin
          regs_q[b][i] <= '0;
        end
      end
      ixz_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      ixz_q  <= ixz_d;
    end
  end

  assign OUTA = regs_q[bsel_q][RA];
  assign OUTB = regs_q[bsel_q][RB];
  assign OUTC = {WIDTH{CSEL}};
  assign OIX  = regs_q[bsel_q][IX_IDX];
  assign IXZ  = ixz_q;

  for (genvar i = 0; i < NREGS; i++) begin : g_regs
    assign REGS[i*WIDTH +: WIDTH] = regs_q[bsel_q][i];
  end

endmodule

// File: tb/tb_mainreg_bank.sv
// Directed self-checking bench for mainreg_bank (WIDTH=8, NREGS=4).
// Shadow-bank scenario runs only when MAINREG_BANK_SHADOW_EN is defined.
module tb_mainreg_bank;

  logic        CLK = 1'b0;
  logic        RESET;
`ifdef MAINREG_BANK_SHADOW_EN
  logic        EXX;
`endif
  logic [1:0]  OP;
  logic [1:0]  WA;
  logic [7:0]  IN;
  logic [1:0]  RA;
  logic [1:0]  RB;
  logic        CSEL;
  logic [7:0]  STEP;
  logic [7:0]  OUTA;
  logic [7:0]  OUTB;
  logic [7:0]  OUTC;
  logic [7:0]  OIX;
  logic        IXZ;
  logic [31:0] REGS;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 CLK = ~CLK;

  mainreg_bank #(.WIDTH(8), .NREGS(4)) dut (
    .CLK  (CLK),
    .RESET(RESET),
`ifdef MAINREG_BANK_SHADOW_EN
    .EXX  (EXX),
`endif
    .OP   (OP),
    .WA   (WA),
    .IN   (IN),
    .RA   (RA),
    .RB   (RB),
    .CSEL (CSEL),
    .STEP (STEP),
    .OUTA (OUTA),
    .OUTB (OUTB),
    .OUTC (OUTC),
    .OIX  (OIX),
    .IXZ  (IXZ),
    .REGS (REGS)
  );

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; OP = 2'b00; RA = 2'd0; RB = 2'd3; CSEL = 1'b1;
    step();
    RESET = 1'b0;
    #1;
    total_cnt++; if (OUTA !== 8'h00) $display("FAIL reset_outa got %h want 00", OUTA); else pass_cnt++;
    total_cnt++; if (OUTB !== 8'h00) $display("FAIL reset_outb got %h want 00", OUTB); else pass_cnt++;
    total_cnt++; if (OIX !== 8'h00) $display("FAIL reset_oix got %h want 00", OIX); else pass_cnt++;
    total_cnt++; if (IXZ !== 1'b0) $display("FAIL reset_ixz got %b want 0", IXZ); else pass_cnt++;
    total_cnt++; if (REGS !== 32'h0) $display("FAIL reset_regs got %h want 0", REGS); else pass_cnt++;
    total_cnt++; if (OUTC !== 8'hFF) $display("FAIL outc_ones got %h want ff", OUTC); else pass_cnt++;
    CSEL = 1'b0;
    #1;
    total_cnt++; if (OUTC !== 8'h00) $display("FAIL outc_zeros got %h want 00", OUTC); else pass_cnt++;
  endtask

  task automatic test_write_read();
    OP = 2'b01; WA = 2'd0; IN = 8'h3C; RA = 2'd0;
    #1;
    total_cnt++; if (OUTA !== 8'h00) $display("FAIL no_bypass got %h want 00", OUTA); else pass_cnt++;
    step();
    OP = 2'b01; WA = 2'd2; IN = 8'hA5;
    step();
    OP = 2'b00; RA = 2'd0; RB = 2'd2;
    #1;
    total_cnt++; if (OUTA !== 8'h3C) $display("FAIL write_outa got %h want 3c", OUTA); else pass_cnt++;
    total_cnt++; if (OUTB !== 8'hA5) $display("FAIL write_outb got %h want a5", OUTB); else pass_cnt++;
    total_cnt++; if (REGS !== 32'h00A5003C) $display("FAIL write_regs got %h want 00a5003c", REGS); else pass_cnt++;
  endtask

  task automatic test_swap();
    OP = 2'b01; WA = 2'd0; IN = 8'h11; step();
    WA = 2'd1; IN = 8'h22; step();
    WA = 2'd3; IN = 8'h99; step();
    OP = 2'b10; RA = 2'd0; RB = 2'd1; step();
    OP = 2'b00;
    #1;
    total_cnt++; if (OUTA !== 8'h22) $display("FAIL swap_r0 got %h want 22", OUTA); else pass_cnt++;
    total_cnt++; if (OUTB !== 8'h11) $display("FAIL swap_r1 got %h want 11", OUTB); else pass_cnt++;
    OP = 2'b10; RA = 2'd1; RB = 2'd1; step();
    OP = 2'b00;
    #1;
    total_cnt++; if (REGS !== 32'h99A51122) $display("FAIL swap_same got %h want 99a51122", REGS); else pass_cnt++;
    OP = 2'b10; RA = 2'd3; RB = 2'd0; step();
    OP = 2'b00;
    #1;
    total_cnt++; if (OIX !== 8'h22) $display("FAIL swap_ix got %h want 22", OIX); else pass_cnt++;
    total_cnt++; if (OUTB !== 8'h99) $display("FAIL swap_ix_r0 got %h want 99", OUTB); else pass_cnt++;
    total_cnt++; if (IXZ !== 1'b0) $display("FAIL swap_ixz got %b want 0", IXZ); else pass_cnt++;
  endtask

  task automatic test_ix_wrap();
    OP = 2'b01; WA = 2'd3; IN = 8'hFE; step();
    OP = 2'b11; STEP = 8'h01; step();
    total_cnt++; if (OIX !== 8'hFF) $display("FAIL ix_ff got %h want ff", OIX); else pass_cnt++;
    total_cnt++; if (IXZ !== 1'b0) $display("FAIL ixz_ff got %b want 0", IXZ); else pass_cnt++;
    step();
    total_cnt++; if (OIX !== 8'h00) $display("FAIL ix_wrap got %h want 00", OIX); else pass_cnt++;
    total_cnt++; if (IXZ !== 1'b1) $display("FAIL ixz_wrap got %b want 1", IXZ); else pass_cnt++;
    OP = 2'b00; step();
    total_cnt++; if (IXZ !== 1'b1) $display("FAIL ixz_hold got %b want 1", IXZ); else pass_cnt++;
    OP = 2'b11; STEP = 8'hFF; step();
    total_cnt++; if (OIX !== 8'hFF) $display("FAIL ix_down got %h want ff", OIX); else pass_cnt++;
    total_cnt++; if (IXZ !== 1'b0) $display("FAIL ixz_down got %b want 0", IXZ); else pass_cnt++;
    OP = 2'b01; WA = 2'd3; IN = 8'h00; step();
    total_cnt++; if (IXZ !== 1'b0) $display("FAIL ixz_write got %b want 0", IXZ); else pass_cnt++;
    OP = 2'b11; STEP = 8'h00; step();
    total_cnt++; if (IXZ !== 1'b1) $display("FAIL ixz_step0 got %b want 1", IXZ); else pass_cnt++;
    OP = 2'b00;
  endtask

  task automatic test_reset_mid();
    RESET = 1'b1; OP = 2'b01; WA = 2'd1; IN = 8'h77; step();
    total_cnt++; if (REGS !== 32'h0) $display("FAIL rst_mid_regs got %h want 0", REGS); else pass_cnt++;
    total_cnt++; if (IXZ !== 1'b0) $display("FAIL rst_mid_ixz got %b want 0", IXZ); else pass_cnt++;
    RESET = 1'b0; step();
    OP = 2'b00; RA = 2'd1;
    #1;
    total_cnt++; if (OUTA !== 8'h77) $display("FAIL rst_release got %h want 77", OUTA); else pass_cnt++;
  endtask

`ifdef MAINREG_BANK_SHADOW_EN
  task automatic test_shadow();
    RESET = 1'b1; EXX = 1'b0; OP = 2'b00; step();
    RESET = 1'b0;
    OP = 2'b01; WA = 2'd0; IN = 8'h55; step();
    OP = 2'b00; EXX = 1'b1; step();
    EXX = 1'b0; RA = 2'd0;
    #1;
    total_cnt++; if (OUTA !== 8'h00) $display("FAIL shadow_empty got %h want 00", OUTA); else pass_cnt++;
    OP = 2'b01; WA = 2'd0; IN = 8'hAA; EXX = 1'b1; step();
    OP = 2'b00; EXX = 1'b0;
    #1;
    total_cnt++; if (OUTA !== 8'h55) $display("FAIL shadow_back got %h want 55", OUTA); else pass_cnt++;
    EXX = 1'b1; step();
    EXX = 1'b0;
    #1;
    total_cnt++; if (OUTA !== 8'hAA) $display("FAIL shadow_aa got %h want aa", OUTA); else pass_cnt++;
  endtask
`endif

  initial begin
    RESET = 1'b0; OP = 2'b00; WA = '0; IN = '0; RA = '0; RB = '0; CSEL = 1'b0; STEP = '0;
`ifdef MAINREG_BANK_SHADOW_EN
    EXX = 1'b0;
`endif
    test_reset();
    test_write_read();
    test_swap();
    test_ix_wrap();
    test_reset_mid();
`ifdef MAINREG_BANK_SHADOW_EN
    test_shadow();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
